// File: rtl/sccb_config_seq.sv
// sccb_config_seq: walks an external command ROM and issues SCCB register
// writes, read-back verifies and timed delays on an OCP-style master port,
// with retry-on-error, abort on kick release and error reporting.
module sccb_config_seq #(
  parameter int unsigned ROM_AW    = 8,
  parameter logic [6:0]  DEV_ID    = 7'h21,
  parameter logic [7:0]  SCCB_DIV  = 8'd100,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              config_clk,
  input  logic              config_reset_n,
  input  logic              sccb_kick,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [1:0]        rom_cmd,
  input  logic [7:0]        rom_reg,
  input  logic [7:0]        rom_data,
  output logic [7:0]        sccb_div,
  output logic [2:0]        mcmd,
  output logic [14:0]       maddr,
  output logic [7:0]        mdata,
  input  logic              scmdaccept,
  input  logic [1:0]        sresp,
  input  logic [7:0]        sdata,
  output logic              sccb_busy,
  output logic              sccb_done,
  output logic              sccb_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned DLY_W   = 16;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  localparam logic [1:0] CMD_END = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_WRV = 2'b10;
  localparam logic [1:0] CMD_DLY = 2'b11;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP,
    S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t             state;
  state_t             resp_next;
  state_t             fail_next;
  logic               kick_s1;
  logic               kick_s2;
  logic               kick_d;
  logic               kick_rise;
  logic               abort_q;
  logic               abort_now;
  logic               ent_verify;
  logic               resp_take;
  logic               is_rd;
  logic [RETRY_W-1:0] retry;
  logic [DLY_W-1:0]   dly_cnt;

  assign sccb_div  = SCCB_DIV;
  assign kick_rise = kick_s2 & ~kick_d;
  assign abort_now = abort_q | ~kick_s2;

  // Response decode: where a consumed (or pending) master response leads.
  always_comb begin
    resp_take = 1'b0;
    resp_next = state;
    is_rd     = (state == S_RD_REQ) || (state == S_RD_RESP);
    fail_next = (retry < RETRY_MAX) ? S_WR_REQ : S_ERROR;
    case (state)
      S_WR_REQ, S_RD_REQ:   resp_take = scmdaccept;
      S_WR_RESP, S_RD_RESP: resp_take = 1'b1;
      default:              resp_take = 1'b0;
    endcase
    if (sresp == RESP_NONE)     resp_next = is_rd ? S_RD_RESP : S_WR_RESP;
    else if (abort_now)         resp_next = S_IDLE;
    else if (sresp != RESP_DVA) resp_next = fail_next;
    else if (is_rd)             resp_next = (sdata == mdata) ? S_NEXT : fail_next;
    else                        resp_next = ent_verify ? S_RD_REQ : S_NEXT;
  end

  // Sequencer FSM with kick synchroniser and registered outputs.
  always_ff @(posedge config_clk) begin
    if (!config_reset_n) begin
      state      <= S_IDLE;
      kick_s1    <= 1'b0;
      kick_s2    <= 1'b0;
      kick_d     <= 1'b0;
      abort_q    <= 1'b0;
      ent_verify <= 1'b0;
      rom_addr   <= '0;
      mcmd       <= MCMD_IDLE;
      maddr      <= {DEV_ID, 8'h00};
      mdata      <= 8'h00;
      sccb_busy  <= 1'b0;
      sccb_done  <= 1'b0;
      sccb_err   <= 1'b0;
      err_index  <= '0;
      retry      <= '0;
      dly_cnt    <= '0;
    end else begin
      kick_s1 <= sccb_kick;
      kick_s2 <= kick_s1;
      kick_d  <= kick_s2;
      if (sccb_busy && !kick_s2) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (kick_rise) begin
            state     <= S_FETCH;
            rom_addr  <= '0;
            retry     <= '0;
            sccb_busy <= 1'b1;
            sccb_done <= 1'b0;
            sccb_err  <= 1'b0;
            err_index <= '0;
          end
        end
        S_FETCH: begin
          if (abort_now) begin
            state     <= S_IDLE;
            sccb_busy <= 1'b0;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (abort_now) begin
            state     <= S_IDLE;
            sccb_busy <= 1'b0;
          end else begin
            case (rom_cmd)
              CMD_END: begin
                state     <= S_DONE;
                sccb_busy <= 1'b0;
                sccb_done <= 1'b1;
              end
              CMD_WR, CMD_WRV: begin
                state      <= S_WR_REQ;
                mcmd       <= MCMD_WR;
                maddr      <= {DEV_ID, rom_reg};
                mdata      <= rom_data;
                ent_verify <= (rom_cmd == CMD_WRV);
              end
              CMD_DLY: begin
                dly_cnt <= {rom_reg, rom_data};
                state   <= ({rom_reg, rom_data} == '0) ? S_NEXT : S_DELAY;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP: begin
          if (resp_take) begin
            mcmd  <= MCMD_IDLE;
            state <= resp_next;
            case (resp_next)
              S_IDLE:   sccb_busy <= 1'b0;
              S_RD_REQ: mcmd <= MCMD_RD;
              S_WR_REQ: begin
                mcmd  <= MCMD_WR;
                retry <= retry + 4'd1;
              end
              S_ERROR: begin
                sccb_busy <= 1'b0;
                sccb_err  <= 1'b1;
                err_index <= rom_addr;
              end
              default: ;
            endcase
          end
        end
        S_DELAY: begin
          if (abort_now) begin
            state     <= S_IDLE;
            sccb_busy <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
            if (dly_cnt == 16'd1) state <= S_NEXT;
          end
        end
        S_NEXT: begin
          retry <= '0;
          if (abort_now) begin
            state     <= S_IDLE;
            sccb_busy <= 1'b0;
          end else if (&rom_addr) begin
            state     <= S_DONE;
            sccb_busy <= 1'b0;
            sccb_done <= 1'b1;
          end else begin
            rom_addr <= rom_addr + ROM_AW'(1);
            state    <= S_FETCH;
          end
        end
        S_DONE, S_ERROR: begin
          if (!kick_s2) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// tb_sccb_config_seq: directed bench for sccb_config_seq with a ROM model,
// a configurable SCCB master responder and a ROM_AW=2 second instance.
module tb_sccb_config_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // instance 1 (ROM_AW=8)
  logic        kick;
  logic [7:0]  rom_addr;
  logic [1:0]  rom_cmd;
  logic [7:0]  rom_reg, rom_data;
  logic [7:0]  sccb_div;
  logic [2:0]  mcmd;
  logic [14:0] maddr;
  logic [7:0]  mdata;
  logic        scmdaccept;
  logic [1:0]  sresp;
  logic [7:0]  sdata;
  logic        busy, done, err;
  logic [7:0]  err_index;
  // instance 2 (ROM_AW=2)
  logic        kick2;
  logic [1:0]  rom_addr2;
  logic [1:0]  rom_cmd2;
  logic [7:0]  rom_reg2, rom_data2;
  logic [7:0]  sccb_div2;
  logic [2:0]  mcmd2;
  logic [14:0] maddr2;
  logic [7:0]  mdata2;
  logic        scmdaccept2;
  logic [1:0]  sresp2;
  logic [7:0]  sdata2;
  logic        busy2, done2, err2;
  logic [1:0]  err_index2;

  sccb_config_seq u_dut (
    .config_clk(clk), .config_reset_n(rst_n), .sccb_kick(kick),
    .rom_addr(rom_addr), .rom_cmd(rom_cmd), .rom_reg(rom_reg), .rom_data(rom_data),
    .sccb_div(sccb_div), .mcmd(mcmd), .maddr(maddr), .mdata(mdata),
    .scmdaccept(scmdaccept), .sresp(sresp), .sdata(sdata),
    .sccb_busy(busy), .sccb_done(done), .sccb_err(err), .err_index(err_index)
  );

  sccb_config_seq #(.ROM_AW(2)) u_dut2 (
    .config_clk(clk), .config_reset_n(rst_n), .sccb_kick(kick2),
    .rom_addr(rom_addr2), .rom_cmd(rom_cmd2), .rom_reg(rom_reg2), .rom_data(rom_data2),
    .sccb_div(sccb_div2), .mcmd(mcmd2), .maddr(maddr2), .mdata(mdata2),
    .scmdaccept(scmdaccept2), .sresp(sresp2), .sdata(sdata2),
    .sccb_busy(busy2), .sccb_done(done2), .sccb_err(err2), .err_index(err_index2)
  );

  // Synchronous ROMs: data valid the cycle after the address.
  logic [17:0] rom_mem  [0:255];
  logic [17:0] rom2_mem [0:3];
  logic [17:0] rom_q, rom2_q;
  always @(posedge clk) rom_q  <= rom_mem[rom_addr];
  always @(posedge clk) rom2_q <= rom2_mem[rom_addr2];
  assign {rom_cmd, rom_reg, rom_data}    = rom_q;
  assign {rom_cmd2, rom_reg2, rom_data2} = rom2_q;

  // Instance 2 master: accepts and answers DVA in the same cycle.
  assign scmdaccept2 = (mcmd2 != 3'b000);
  assign sresp2      = scmdaccept2 ? 2'b01 : 2'b00;
  assign sdata2      = 8'h00;

  // Responder configuration (written by the main sequence only).
  int         acc_dly = 2;
  int         resp_dly = 5;
  int         err_total = 0;
  logic [7:0] rd_data = 8'h00;
  int         epoch = 0;

  // Responder state and logs (written by the responder only).
  int          n_wr = 0, n_rd = 0, err_given = 0;
  logic [14:0] wr_addr_log [0:63];
  logic [7:0]  wr_data_log [0:63];
  logic [14:0] rd_addr_last = 15'h0;

  // Instance 1 master responder: accept after acc_dly, answer resp_dly later.
  initial begin
    bit pending, pend_rd;
    int acc_cnt, resp_cnt;
    pending = 0; pend_rd = 0; acc_cnt = 0; resp_cnt = 0;
    scmdaccept = 1'b0; sresp = 2'b00; sdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      scmdaccept = 1'b0;
      sresp      = 2'b00;
      if (!rst_n) begin
        pending = 0; acc_cnt = 0; resp_cnt = 0;
      end else if (pending) begin
        resp_cnt++;
        if (resp_cnt > resp_dly) begin
          pending = 0;
          if (!pend_rd && err_given < err_total) begin
            sresp = 2'b11;
            err_given++;
          end else begin
            sresp = 2'b01;
            sdata = pend_rd ? rd_data : 8'h00;
          end
        end
      end else if (mcmd != 3'b000) begin
        acc_cnt++;
        if (acc_cnt > acc_dly) begin
          scmdaccept = 1'b1;
          pending    = 1;
          resp_cnt   = 0;
          acc_cnt    = 0;
          pend_rd    = (mcmd == 3'b010);
          if (pend_rd) begin
            n_rd++;
            rd_addr_last = maddr;
          end else begin
            if (n_wr < 64) begin
              wr_addr_log[n_wr] = maddr;
              wr_data_log[n_wr] = mdata;
            end
            n_wr++;
          end
        end
      end
    end
  end

  // Monitor: highest rom_addr, idle-mcmd gap after first write, instance-2 writes.
  int max_addr = 0, gap = 0, gph = 0, n_wr2 = 0;
  initial begin
    int mon_epoch;
    mon_epoch = 0;
    forever begin
      @(posedge clk); #1;
      if (epoch != mon_epoch) begin
        mon_epoch = epoch; max_addr = 0; gap = 0; gph = 0; n_wr2 = 0;
      end
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (mcmd2 == 3'b001) n_wr2++;
      case (gph)
        0: if (mcmd == 3'b001) gph = 1;
        1: if (mcmd == 3'b000) begin gph = 2; gap = 1; end
        2: if (mcmd == 3'b000) gap++; else gph = 3;
        default: ;
      endcase
    end
  end

  int n_vec = 0, n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [17:0] ent(input logic [1:0] c, input logic [7:0] r, input logic [7:0] d);
    return {c, r, d};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom_mem[i] = 18'h0;
  endtask

  task automatic start(input string tag);
    int k;
    k = 0;
    kick = 1'b1;
    while (!busy && k < 10) begin cyc(1); k++; end
    check({tag, "_start"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k;
    k = 0;
    while (!(done || err) && k < budget) begin cyc(1); k++; end
    check({tag, "_in_time"}, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int b, br, k;
    #400_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, br, k;
    rst_n = 1'b0; kick = 1'b0; kick2 = 1'b0;
    rom_clear();
    for (int i = 0; i < 4; i++) rom2_mem[i] = ent(2'b01, 8'(i), 8'(8'hC0 + i));
    cyc(3);

    // reset state
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_mcmd", 32'(mcmd), 32'h0);
    check("rst_maddr", 32'(maddr), 32'h2100);
    check("rst_mdata", 32'(mdata), 32'h0);
    check("rst_flags", {29'h0, busy, done, err}, 32'h0);
    check("rst_err_index", 32'(err_index), 32'h0);
    check("sccb_div", 32'(sccb_div), 32'd100);
    rst_n = 1'b1;
    cyc(2);

    // three plain writes, end at entry 3
    rom_mem[0] = ent(2'b01, 8'h10, 8'hA1);
    rom_mem[1] = ent(2'b01, 8'h11, 8'hA2);
    rom_mem[2] = ent(2'b01, 8'h12, 8'hA3);
    rom_mem[3] = ent(2'b00, 8'h00, 8'h00);
    epoch++; b = n_wr; br = n_rd;
    start("wr3");
    wait_end("wr3", 300);
    check("wr3_flags", {29'h0, busy, done, err}, 32'b010);
    check("wr3_nwr", 32'(n_wr - b), 32'd3);
    check("wr3_nrd", 32'(n_rd - br), 32'd0);
    check("wr3_addr0", 32'(wr_addr_log[b]), 32'h2110);
    check("wr3_data0", 32'(wr_data_log[b]), 32'hA1);
    check("wr3_addr2", 32'(wr_addr_log[b + 2]), 32'h2112);
    check("wr3_data2", 32'(wr_data_log[b + 2]), 32'hA3);
    check("wr3_max_addr", 32'(max_addr), 32'd3);
    cyc(20);
    check("wr3_no_restart_nwr", 32'(n_wr - b), 32'd3);
    check("wr3_no_restart_flags", {29'h0, busy, done, err}, 32'b010);
    kick = 1'b0;
    cyc(5);
    check("wr3_done_held", 32'(done), 32'd1);

    // write+verify, read-back matches
    rom_clear();
    rom_mem[0] = ent(2'b10, 8'h12, 8'h80);
    rd_data = 8'h80;
    b = n_wr; br = n_rd;
    start("vfy_ok");
    wait_end("vfy_ok", 300);
    check("vfy_ok_flags", {29'h0, busy, done, err}, 32'b010);
    check("vfy_ok_nwr", 32'(n_wr - b), 32'd1);
    check("vfy_ok_nrd", 32'(n_rd - br), 32'd1);
    check("vfy_ok_rd_addr", 32'(rd_addr_last), 32'h2112);
    kick = 1'b0;
    cyc(5);

    // write+verify at entry 1, read-back always wrong -> 3 rewrites then error
    rom_mem[0] = ent(2'b01, 8'h30, 8'h55);
    rom_mem[1] = ent(2'b10, 8'h12, 8'h80);
    rom_mem[2] = ent(2'b00, 8'h00, 8'h00);
    rd_data = 8'h00;
    b = n_wr; br = n_rd;
    start("vfy_bad");
    wait_end("vfy_bad", 600);
    check("vfy_bad_flags", {29'h0, busy, done, err}, 32'b001);
    check("vfy_bad_err_index", 32'(err_index), 32'd1);
    check("vfy_bad_nwr", 32'(n_wr - b), 32'd5);
    check("vfy_bad_nrd", 32'(n_rd - br), 32'd4);
    kick = 1'b0;
    cyc(5);
    check("vfy_bad_err_held", {31'h0, err}, 32'd1);
    check("vfy_bad_index_held", 32'(err_index), 32'd1);

    // ERR twice on entry 0, then DVA; sequence completes
    rom_clear();
    rom_mem[0] = ent(2'b01, 8'h20, 8'h01);
    rom_mem[1] = ent(2'b01, 8'h21, 8'h02);
    err_total = err_total + 2;
    b = n_wr;
    start("retry");
    wait_end("retry", 400);
    check("retry_flags", {29'h0, busy, done, err}, 32'b010);
    check("retry_nwr", 32'(n_wr - b), 32'd4);
    check("retry_third_issue", 32'(wr_addr_log[b + 2]), 32'h2120);
    check("retry_next_entry", 32'(wr_addr_log[b + 3]), 32'h2121);
    kick = 1'b0;
    cyc(5);

    // 256-cycle delay between two writes; immediate accept and response
    rom_clear();
    rom_mem[0] = ent(2'b01, 8'h40, 8'h11);
    rom_mem[1] = ent(2'b11, 8'h01, 8'h00);
    rom_mem[2] = ent(2'b01, 8'h41, 8'h22);
    acc_dly = 0; resp_dly = 0;
    epoch++; b = n_wr;
    start("dly");
    wait_end("dly", 600);
    check("dly_flags", {29'h0, busy, done, err}, 32'b010);
    check("dly_nwr", 32'(n_wr - b), 32'd2);
    // idle mcmd: WR_RESP, NEXT, FETCH, DECODE, 256 x DELAY, NEXT, FETCH, DECODE
    check("dly_gap", 32'(gap), 32'd263);
    kick = 1'b0;
    cyc(5);

    // abort while waiting for a write response, then restart from entry 0
    rom_clear();
    rom_mem[0] = ent(2'b01, 8'h50, 8'h01);
    rom_mem[1] = ent(2'b01, 8'h51, 8'h02);
    resp_dly = 20;
    b = n_wr;
    start("abort");
    k = 0;
    while (n_wr == b && k < 20) begin cyc(1); k++; end
    check("abort_accepted", 32'(n_wr - b), 32'd1);
    cyc(2);
    kick = 1'b0;
    cyc(6);
    check("abort_waits_resp", {30'h0, busy, (mcmd == 3'b000)}, 32'b11);
    cyc(30);
    check("abort_flags", {29'h0, busy, done, err}, 32'b000);
    check("abort_nwr", 32'(n_wr - b), 32'd1);
    b = n_wr;
    start("rekick");
    wait_end("rekick", 400);
    check("rekick_flags", {29'h0, busy, done, err}, 32'b010);
    check("rekick_nwr", 32'(n_wr - b), 32'd2);
    check("rekick_first_addr", 32'(wr_addr_log[b]), 32'h2150);
    kick = 1'b0;
    cyc(5);

    // ROM_AW=2 with no end entry: all four entries, rom_addr holds 3
    epoch++;
    cyc(1);
    kick2 = 1'b1;
    k = 0;
    while (!done2 && k < 100) begin cyc(1); k++; end
    check("aw2_in_time", 32'(k < 100), 32'd1);
    check("aw2_flags", {29'h0, busy2, done2, err2}, 32'b010);
    check("aw2_nwr", 32'(n_wr2), 32'd4);
    cyc(5);
    check("aw2_rom_addr_hold", 32'(rom_addr2), 32'd3);

    // reset in the middle of a write request
    rom_clear();
    rom_mem[0] = ent(2'b01, 8'h60, 8'h77);
    acc_dly = 4; resp_dly = 5;
    start("midrst");
    k = 0;
    while (mcmd != 3'b001 && k < 20) begin cyc(1); k++; end
    check("midrst_mcmd_seen", 32'(mcmd), 32'h1);
    rst_n = 1'b0; kick = 1'b0; kick2 = 1'b0;
    cyc(1);
    check("midrst_mcmd", 32'(mcmd), 32'h0);
    check("midrst_rom_addr", 32'(rom_addr), 32'h0);
    check("midrst_maddr", 32'(maddr), 32'h2100);
    check("midrst_mdata", 32'(mdata), 32'h0);
    check("midrst_flags", {29'h0, busy, done, err}, 32'b000);
    check("midrst_flags2", {29'h0, busy2, done2, err2}, 32'b000);
    check("midrst_dut2_bus", {maddr2, 1'b0, mdata2, 5'h0, mcmd2}, {15'h2100, 17'h0});
    check("midrst_dut2_idx", {22'h0, err_index2, rom_addr2, sccb_div2}, 32'd100);
    rst_n = 1'b1;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
